// File: rtl/tft_console.sv
// ----------------------------------------------------------------------------
// tft_console
//
// Text-terminal writer for the TFT text memory (COLS x ROWS character cells,
// 8-bit codes). Accepts a byte stream over valid/ready, keeps a cursor,
// interprets a small set of control codes and drives the write-only text
// memory port feeding the TFT display controller.
//
// Ports
//   clk              system clock
//   reset            asynchronous assert, active-low reset
//   char_valid       char_data is valid
//   char_data[7:0]   character or control code
//   char_ready       block accepts char_data this cycle (combinational)
//   clear_req        one-cycle request: clear screen and home the cursor
//   text_write_en    text memory write strobe (registered)
//   text_write_addr  text memory address = row*COLS+col (registered)
//   text_write_data  text memory write data (registered)
//   cursor_col[6:0]  current cursor column, 0..COLS-1
//   cursor_row[4:0]  current cursor row, 0..ROWS-1
//   busy             a clear sequence is in progress (state != IDLE)
//
// Control codes
//   0x20..0x7E  printable: written at cursor, cursor advances
//   0x0A LF     column 0, next row (no write)
//   0x0D CR     column 0 (no write)
//   0x08 BS     column-1 and blank that cell; no-op at column 0
//   0x0C FF     clear screen, same as clear_req
//   others      accepted and dropped
//
// Build option
//   TFT_CONSOLE_CLEAR_ROW_EN  when defined, every row advance blanks the
//                             newly entered row (CLR_ROW state). When not
//                             defined the cursor simply moves.
// ----------------------------------------------------------------------------
module tft_console #(
  parameter int         COLS      = 80,
  parameter int         ROWS      = 32,
  parameter int         ADDR_W    = 12,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  output logic              char_ready,
  input  logic              clear_req,
  output logic              text_write_en,
  output logic [ADDR_W-1:0] text_write_addr,
  output logic [7:0]        text_write_data,
  output logic [6:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
  localparam logic [6:0]        LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);

`ifdef TFT_CONSOLE_CLEAR_ROW_EN
  typedef enum logic [1:0] {IDLE, CLR_ALL, CLR_ROW} state_t;
`else
  typedef enum logic [1:0] {IDLE, CLR_ALL} state_t;
`endif

  state_t              state_reg, state_next;
  logic [6:0]          col_reg, col_next;
  logic [4:0]          row_reg, row_next;
  logic                we_reg, we_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [7:0]          data_reg, data_next;
  // Clear sequencer: next address to emit, last address of the run, and a
  // flag set once the last address has been emitted (the state then returns
  // to IDLE on the following edge, so busy covers exactly the write cycles).
  logic [ADDR_W-1:0]   clr_addr_reg, clr_addr_next;
  logic [ADDR_W-1:0]   clr_last_reg, clr_last_next;
  logic                clr_done_reg, clr_done_next;

  logic                accept;
  logic                printable;
  logic [4:0]          row_adv;
  logic [ADDR_W-1:0]   cur_addr;
`ifdef TFT_CONSOLE_CLEAR_ROW_EN
  logic [ADDR_W-1:0]   adv_base;
`endif

  assign accept    = char_valid && char_ready;
  assign printable = (char_data >= 8'h20) && (char_data <= 8'h7E);
  // Row advance wraps to the top; there is no scrolling.
  assign row_adv   = (row_reg == LAST_ROW) ? 5'd0 : row_reg + 5'd1;
  assign cur_addr  = ADDR_W'(row_reg) * ADDR_W'(COLS) + ADDR_W'(col_reg);
`ifdef TFT_CONSOLE_CLEAR_ROW_EN
  assign adv_base  = ADDR_W'(row_adv) * ADDR_W'(COLS);
`endif

  // --------------------------------------------------------------------------
  // State and datapath register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      col_reg      <= 7'd0;
      row_reg      <= 5'd0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      data_reg     <= 8'h00;
      clr_addr_reg <= '0;
      clr_last_reg <= '0;
      clr_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      col_reg      <= col_next;
      row_reg      <= row_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      data_reg     <= data_next;
      clr_addr_reg <= clr_addr_next;
      clr_last_reg <= clr_last_next;
      clr_done_reg <= clr_done_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    col_next      = col_reg;
    row_next      = row_reg;
    we_next       = 1'b0;
    addr_next     = addr_reg;
    data_next     = data_reg;
    clr_addr_next = clr_addr_reg;
    clr_last_next = clr_last_reg;
    clr_done_next = clr_done_reg;

    case (state_reg)
      IDLE: begin
        if (clear_req || (accept && char_data == 8'h0C)) begin
          // Full clear: first write goes out with the triggering edge.
          state_next    = CLR_ALL;
          col_next      = 7'd0;
          row_next      = 5'd0;
          we_next       = 1'b1;
          addr_next     = '0;
          data_next     = FILL_CHAR;
          clr_addr_next = ADDR_W'(1);
          clr_last_next = LAST_ADDR;
          clr_done_next = (LAST_ADDR == '0);
        end else if (accept) begin
          if (printable) begin
            we_next   = 1'b1;
            addr_next = cur_addr;
            data_next = char_data;
            if (col_reg == LAST_COL) begin
              col_next = 7'd0;
              row_next = row_adv;
`ifdef TFT_CONSOLE_CLEAR_ROW_EN
              // The character's own write occupies this edge; the row clear
              // starts on the next one.
              state_next    = CLR_ROW;
              clr_addr_next = adv_base;
              clr_last_next = adv_base + ADDR_W'(COLS - 1);
              clr_done_next = 1'b0;
`endif
            end else begin
              col_next = col_reg + 7'd1;
            end
          end else begin
            case (char_data)
              8'h0A: begin
                col_next = 7'd0;
                row_next = row_adv;
`ifdef TFT_CONSOLE_CLEAR_ROW_EN
                state_next    = CLR_ROW;
                we_next       = 1'b1;
                addr_next     = adv_base;
                data_next     = FILL_CHAR;
                clr_addr_next = adv_base + ADDR_W'(1);
                clr_last_next = adv_base + ADDR_W'(COLS - 1);
                clr_done_next = (COLS == 1);
`endif
              end
              8'h0D: col_next = 7'd0;
              8'h08: begin
                // Backspace never moves to the previous row.
                if (col_reg != 7'd0) begin
                  col_next  = col_reg - 7'd1;
                  we_next   = 1'b1;
                  addr_next = cur_addr - ADDR_W'(1);
                  data_next = FILL_CHAR;
                end
              end
              default: ;
            endcase
          end
        end
      end

      default: begin
        // CLR_ALL and CLR_ROW share the sequencer.
        if (clr_done_reg) begin
          state_next = IDLE;
        end else begin
          we_next       = 1'b1;
          addr_next     = clr_addr_reg;
          data_next     = FILL_CHAR;
          clr_addr_next = clr_addr_reg + ADDR_W'(1);
          clr_done_next = (clr_addr_reg == clr_last_reg);
        end
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    char_ready = (state_reg == IDLE) && !clear_req;
    busy       = (state_reg != IDLE);
  end

  assign text_write_en   = we_reg;
  assign text_write_addr = addr_reg;
  assign text_write_data = data_reg;
  assign cursor_col      = col_reg;
  assign cursor_row      = row_reg;

endmodule
